// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one full-subtractor
// cell plus a borrow flip-flop, with a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One full-subtractor cell; returns {borrow_out, difference_bit}.
  function automatic logic [1:0] fs_cell(input logic ai, input logic bi, input logic bri);
    logic d;
    logic bo;
    d  = ai ^ bi ^ bri;
    bo = (~ai & bi) | (~(ai ^ bi) & bri);
    return {bo, d};
  endfunction

  state_t           state_r;
  state_t           state_n;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic             br_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             ovf_r;
  logic             zero_r;
  logic             busy_r;
  logic             done_r;
  logic             a_msb_r;
  logic             b_msb_r;

  logic             load_s;
  logic             last_s;
  logic [1:0]       cell_s;
  logic [WIDTH-1:0] diff_n_s;

  // Next-state decode, the serial cell and the shifted difference.
  always_comb begin
    state_n  = state_r;
    load_s   = 1'b0;
    last_s   = (cnt_r == LAST_BIT);
    cell_s   = fs_cell(a_sh_r[0], b_sh_r[0], br_r);
    diff_n_s = diff_r >> 1'b1;
    diff_n_s[WIDTH-1] = cell_s[0];
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          load_s  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_n = DONE;
        end else begin
          state_n = RUN;
        end
      end
      DONE: begin
        // A start seen in DONE restarts immediately for back-to-back use.
        if (start) begin
          state_n = RUN;
          load_s  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      br_r    <= 1'b0;
      cnt_r   <= '0;
      diff_r  <= '0;
      bout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n == RUN);
      done_r  <= (state_n == DONE);
      if (load_s) begin
        a_sh_r  <= a;
        b_sh_r  <= b;
        br_r    <= bin;
        cnt_r   <= '0;
        diff_r  <= '0;
        bout_r  <= 1'b0;
        ovf_r   <= 1'b0;
        zero_r  <= 1'b0;
        a_msb_r <= a[WIDTH-1];
        b_msb_r <= b[WIDTH-1];
      end else if (state_r == RUN) begin
        a_sh_r <= a_sh_r >> 1'b1;
        b_sh_r <= b_sh_r >> 1'b1;
        br_r   <= cell_s[1];
        cnt_r  <= cnt_r + CW'(1);
        diff_r <= diff_n_s;
        if (last_s) begin
          bout_r <= cell_s[1];
          ovf_r  <= (a_msb_r != b_msb_r) && (cell_s[0] != a_msb_r);
          zero_r <= (diff_n_s == '0);
        end else begin
          bout_r <= bout_r;
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bout = bout_r;
  assign ovf  = ovf_r;
  assign zero = zero_r;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised bit-serial subtractor: the sequential successor of the single-bit half subtractor in the ALU exercise set. It computes `diff = a - b - bin` over `WIDTH` bits, one bit per clock, LSB first, using one full-subtractor cell and a borrow flip-flop. A start/busy/done handshake lets it sit behind a controller or test bench as a multi-cycle ALU subtract unit. Besides the difference it reports final borrow, signed overflow and zero.

## Interface
- `WIDTH`, default 8: operand and result width; legal range 1..32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request. Sampled on a rising edge; accepted only in IDLE or DONE.
- `a`  in  WIDTH  minuend. Captured when `start` is accepted.
- `b`  in  WIDTH  subtrahend. Captured when `start` is accepted.
- `bin`  in  1  borrow-in, for chaining. Captured when `start` is accepted.
- `busy`  out  1  high while bits are being processed.
- `done`  out  1  one-cycle pulse; results are valid from this cycle on.
- `diff`  out  WIDTH  difference, `a - b - bin` mod 2^WIDTH.
- `bout`  out  1  final borrow. 1 when `a < b + bin` (unsigned).
- `ovf`  out  1  signed two's-complement overflow.
- `zero`  out  1  1 when `diff == 0`.

## Operation
- State machine with three states: IDLE, RUN and DONE.
  - IDLE, start=1: go to RUN. Latch `a`, `b` into shift registers and `bin` into the borrow FF. Set bit counter = 0. Clear `diff`.
  - RUN: each cycle processes bit i (the current LSB of the shift registers), then shifts right. The result bit shifts into `diff` from the MSB side.
  - RUN: when the counter reaches WIDTH-1, the last bit is processed on that edge and the state goes to DONE.
  - DONE: lasts one cycle.
    - start=1: go to RUN with a new capture (back-to-back operation).
    - start=0: go to IDLE.
  - IDLE, start=0: stay in IDLE.
- Per-bit cell, with `br` the borrow FF:
  - `d = a_i ^ b_i ^ br`
  - `br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)`
- On entering DONE:
  - `bout` = final `br_next`.
  - `ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`, using the captured operands.
  - `zero = (diff == 0)`.
- `diff`, `bout`, `ovf` and `zero` hold their values through IDLE until the next accepted start. On accept, `bout`/`ovf`/`zero` clear to 0.
- `start` is ignored in RUN. The operation in progress is not disturbed, and operand inputs may change freely.
- Bit counter width is `$clog2(WIDTH)` or more, and at least 1 bit. With WIDTH=1, RUN lasts exactly one cycle.
- With WIDTH=1 and bin=0, `diff`/`bout` must match the half-subtractor truth table: 0-0=0/0, 1-0=1/0, 0-1=1/1, 1-1=0/0.

## Timing
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE immediately.
  - `busy`, `done`, `diff`, `bout`, `ovf` and `zero` all go to 0.
  - Borrow FF and counter are cleared.
- Reset released: the first edge with rst_n=1 may accept `start`.
- Reset asserted mid-RUN aborts the operation. No `done` is produced, and outputs read 0 while reset is held and after release.
- Start accepted on edge E0:
  - `busy` = 1 from after E0 through edge E0+WIDTH.
  - `done` = 1 for exactly the cycle after edge E0+WIDTH.
  - `busy` = 0 in the `done` cycle.
- Latency from start edge to results valid is WIDTH cycles.
- Back-to-back: start held high in the DONE cycle gives `busy` again after the next edge. Sustained throughput is one result per WIDTH+1 cycles.
- `start` held high continuously: a new operation begins every WIDTH+1 cycles, each with one `done` pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, a=0x35, b=0x12, bin=0 -> after 8 cycles: diff=0x23, bout=0, ovf=0, zero=0. `done` high for exactly 1 cycle; `busy` high for 8 cycles.
- WIDTH=8, a=0x12, b=0x35, bin=0 -> diff=0xDD, bout=1, ovf=0. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Then a=0x5A, b=0x5A, bin=0 -> diff=0x00, zero=1.
- WIDTH=8, a=0x80, b=0x01 -> diff=0x7F, ovf=1, bout=0. Then a=0x7F, b=0xFF -> diff=0x80, ovf=1, bout=1.
- Start pulsed in cycle 3 of RUN with different operands -> ignored; the first result completes unchanged. Start held high in the DONE cycle -> second operation starts, second `done` arrives WIDTH+1 cycles after the first.
- rst_n pulsed low in cycle 4 of RUN (mid-cycle, asynchronously) -> all outputs 0 at once, no `done` pulse. A new start after release computes correctly.
- WIDTH=1 instance, all four (a,b) pairs with bin=0 -> half-subtractor truth table; `done` 1 cycle after each start.
